// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// bcd_serial_adder_ctrl_pkg: shared FSM states and BCD constants for the serial adder
package bcd_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_CORR    = 6;
    localparam int BCD_MAX     = 9;

endpackage

// File: rtl/bcd_serial_adder_ctrl_digit.sv
// bcd_digit_add: one BCD digit of addition with decimal correction
module bcd_digit_add
    import bcd_serial_adder_ctrl_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] x,
    input  logic [BCD_DIGIT_W-1:0] y,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   co
);

    logic [BCD_DIGIT_W:0] t;

    // Correction wraps mod 16, so non-BCD inputs still yield a defined digit
    always_comb begin
        t  = (BCD_DIGIT_W+1)'(x) + (BCD_DIGIT_W+1)'(y) + (BCD_DIGIT_W+1)'(ci);
        co = t > (BCD_DIGIT_W+1)'(BCD_MAX);
        s  = co ? t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR) : t[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: multi-digit BCD adder processing one digit per cycle
module bcd_serial_adder_ctrl
    import bcd_serial_adder_ctrl_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BCD_DIGIT_W*NDIG-1:0] a,
    input  logic [BCD_DIGIT_W*NDIG-1:0] b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*NDIG-1:0] sum,
    output logic                        cout,
    output logic                        err
);

    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int W  = BCD_DIGIT_W * NDIG;

    state_t                 state, state_d;
    logic [IW-1:0]          idx;
    logic [W-1:0]           a_q, b_q;
    logic                   carry;
    logic [BCD_DIGIT_W-1:0] x, y, s;
    logic                   co, last, take;

    assign take = state == IDLE && start;
    assign last = idx == IW'(NDIG - 1);
    assign x    = a_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign y    = b_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];

    bcd_digit_add u_digit (
        .x  (x),
        .y  (y),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state == IDLE ? (start ? ADD : IDLE)
                : state == ADD  ? (last ? DONE : ADD)
                : IDLE;
    end

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (take) begin
            idx   <= '0;
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (state == ADD) begin
            sum[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= s;
            carry <= co;
            err   <= err | (x > BCD_DIGIT_W'(BCD_MAX)) | (y > BCD_DIGIT_W'(BCD_MAX));
            idx   <= last ? '0 : idx + 1'b1;
            if (last)
                cout <= co;
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: scenario tasks checking the serial BCD adder against a decimal model
module tb_bcd_serial_adder_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;
    localparam int NDIR = 6;
    localparam logic [15:0] DA[NDIR] = '{16'h1234, 16'h9999, 16'h9999, 16'h000A, 16'h0042, 16'h0500};
    localparam logic [15:0] DB[NDIR] = '{16'h5678, 16'h0001, 16'h9999, 16'h0000, 16'h0058, 16'h0500};
    localparam logic        DC[NDIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [15:0] DS[NDIR] = '{16'h6912, 16'h0000, 16'h9999, 16'h0010, 16'h0100, 16'h1001};
    localparam logic        DO[NDIR] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic        DE[NDIR] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int total = 0;
    int bad = 0;

    bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Decimal digit-by-digit reference; non-BCD digits follow the same +6 mod 16 rule
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                                  output logic [W-1:0] ms, output logic mco, output logic me);
        int t, da, db, c;
        c  = int'(mc);
        ms = '0;
        me = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            da = int'(ma[4*i +: 4]);
            db = int'(mb[4*i +: 4]);
            if (da > 9 || db > 9) me = 1'b1;
            t = da + db + c;
            if (t > 9) begin
                ms[4*i +: 4] = 4'((t + 6) % 16);
                c = 1;
            end else begin
                ms[4*i +: 4] = 4'(t);
                c = 0;
            end
        end
        mco = c != 0;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++)
            r[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Drives one operation, scrambles operands after the latch edge, captures outputs at done
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          output int lat, output logic [W-1:0] rs, output logic rc, output logic re);
        @(negedge clk);
        a = oa; b = ob; cin = oc; start = 1'b1;
        lat = 0;
        repeat (3 * NDIG + 4) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
            end
            if (done) break;
        end
        if (!done) lat = -1;
        rs = sum; rc = cout; re = err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total += 3;
        if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset busy/done got=%b exp=00", {busy, done}); end
        if (sum !== '0) begin bad++; $display("FAIL reset sum got=%h exp=0000", sum); end
        if ({cout, err} !== 2'b00) begin bad++; $display("FAIL reset cout/err got=%b exp=00", {cout, err}); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int lat; logic [W-1:0] rs; logic rc, re;
        for (int i = 0; i < NDIR; i++) begin
            run_op(DA[i], DB[i], DC[i], lat, rs, rc, re);
            total += 4;
            if (lat !== NDIG + 1) begin bad++; $display("FAIL dir%0d latency got=%0d exp=%0d", i, lat, NDIG + 1); end
            if (rs !== DS[i]) begin bad++; $display("FAIL dir%0d sum got=%h exp=%h", i, rs, DS[i]); end
            if (rc !== DO[i]) begin bad++; $display("FAIL dir%0d cout got=%b exp=%b", i, rc, DO[i]); end
            if (re !== DE[i]) begin bad++; $display("FAIL dir%0d err got=%b exp=%b", i, re, DE[i]); end
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] rs, ea, eb, es; logic ec, rc, re, eo, ee;
        for (int i = 0; i < 24; i++) begin
            ea = rand_bcd(); eb = rand_bcd(); ec = 1'($urandom);
            model(ea, eb, ec, es, eo, ee);
            run_op(ea, eb, ec, lat, rs, rc, re);
            total += 4;
            if (lat !== NDIG + 1) begin bad++; $display("FAIL rnd%0d latency got=%0d exp=%0d", i, lat, NDIG + 1); end
            if (rs !== es) begin bad++; $display("FAIL rnd%0d sum %h+%h+%b got=%h exp=%h", i, ea, eb, ec, rs, es); end
            if (rc !== eo) begin bad++; $display("FAIL rnd%0d cout got=%b exp=%b", i, rc, eo); end
            if (re !== ee) begin bad++; $display("FAIL rnd%0d err got=%b exp=%b", i, re, ee); end
        end
    endtask

    task automatic test_hold();
        int lat; logic [W-1:0] rs; logic rc, re;
        run_op(16'h000A, 16'h0009, 1'b0, lat, rs, rc, re);
        total += 2;
        if (lat !== NDIG + 1) begin bad++; $display("FAIL hold latency got=%0d exp=%0d", lat, NDIG + 1); end
        if ({rs, rc, re} !== {16'h0019, 1'b0, 1'b1}) begin bad++; $display("FAIL hold result got=%h/%b/%b exp=0019/0/1", rs, rc, re); end
        repeat (4) begin
            @(negedge clk);
            total++;
            if ({done, busy, sum, cout, err} !== {2'b00, 16'h0019, 1'b0, 1'b1})
                begin bad++; $display("FAIL hold idle got=%b%b/%h/%b/%b exp=00/0019/0/1", done, busy, sum, cout, err); end
        end
    endtask

    task automatic test_back_to_back();
        int n, d1, d2; logic [W-1:0] s1, s2;
        n = 0; d1 = -1; d2 = -1; s1 = '0; s2 = '0;
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
        repeat (30) begin
            @(negedge clk);
            n++;
            if (n == 1) begin a = 16'h0999; b = 16'h0001; end
            if (done) begin
                if (d1 < 0) begin d1 = n; s1 = sum; end
                else begin d2 = n; s2 = sum; break; end
            end
        end
        start = 1'b0;
        total += 4;
        if (d1 !== NDIG + 1) begin bad++; $display("FAIL b2b first_done got=%0d exp=%0d", d1, NDIG + 1); end
        if (d2 - d1 !== NDIG + 2) begin bad++; $display("FAIL b2b spacing got=%0d exp=%0d", d2 - d1, NDIG + 2); end
        if (s1 !== 16'h5432) begin bad++; $display("FAIL b2b sum1 got=%h exp=5432", s1); end
        if (s2 !== 16'h1000) begin bad++; $display("FAIL b2b sum2 got=%h exp=1000", s2); end
    endtask

    task automatic test_ignore_start();
        int n, extra;
        n = 0; extra = 0;
        @(negedge clk);
        a = 16'h2468; b = 16'h1357; cin = 1'b1; start = 1'b1;
        repeat (3 * NDIG + 4) begin
            @(negedge clk);
            n++;
            start = (n == 2 || n == 4);
            if (n == 2) begin a = 16'h9999; b = 16'h9999; cin = 1'b0; end
            if (done) break;
        end
        start = 1'b0;
        total += 2;
        if (n !== NDIG + 1 || !done) begin bad++; $display("FAIL ignore latency got=%0d exp=%0d", n, NDIG + 1); end
        if ({sum, cout, err} !== {16'h3826, 2'b00}) begin bad++; $display("FAIL ignore result got=%h/%b/%b exp=3826/0/0", sum, cout, err); end
        repeat (8) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL ignore spurious_op got=%0d busy/done cycles exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [W-1:0] rs; logic rc, re;
        @(negedge clk);
        a = 16'h0077; b = 16'h0088; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (sum !== 16'h0065) begin bad++; $display("FAIL midrst partial got=%h exp=0065", sum); end
        rst_n = 1'b0;
        #1;
        total += 3;
        if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst busy/done got=%b exp=00", {busy, done}); end
        if (sum !== '0) begin bad++; $display("FAIL midrst sum got=%h exp=0000", sum); end
        if ({cout, err} !== 2'b00) begin bad++; $display("FAIL midrst cout/err got=%b exp=00", {cout, err}); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h1111, 16'h2222, 1'b0, lat, rs, rc, re);
        total += 2;
        if (lat !== NDIG + 1) begin bad++; $display("FAIL midrst latency got=%0d exp=%0d", lat, NDIG + 1); end
        if ({rs, rc, re} !== {16'h3333, 2'b00}) begin bad++; $display("FAIL midrst after got=%h/%b/%b exp=3333/0/0", rs, rc, re); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
BCD_SERIAL_ADDER_CTRL -- requirements
Module: bcd_serial_adder_ctrl

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits per operand (legal range 1..16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 a  input  4*NDIG  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*NDIG  operand B, packed BCD, same packing as a.
REQ-007 cin  input  1  carry into digit 0.
REQ-008 busy  output  1  high in ADD and DONE.
REQ-009 done  output  1  one-cycle pulse; sum, cout and err are valid while it is high.
REQ-010 sum  output  4*NDIG  packed BCD result.
REQ-011 cout  output  1  decimal carry out of digit NDIG-1.
REQ-012 err  output  1  high when any operand digit of the current operation is greater than 9.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-014 IDLE -> ADD on start=1: latch a, b and cin; clear the digit index, sum, cout and err.
REQ-015 ADD SHALL process exactly one digit per cycle, least-significant digit first.
REQ-016 ADD digit step:
- t = a_i + b_i + carry, as a 5-bit binary sum.
- If t > 9: digit = (t + 6) mod 16 and carry = 1.
- Otherwise: digit = t and carry = 0.
REQ-017 The carry for digit 0 SHALL be the latched cin; the carry for each later digit SHALL be the previous digit's carry.
REQ-018 In each ADD cycle, sum[4i+3:4i] SHALL be written with digit i's result.
REQ-019 In each ADD cycle, err SHALL be set if a_i > 9 or b_i > 9; the arithmetic still follows REQ-016 (no special handling).
REQ-020 ADD -> DONE after digit NDIG-1 is processed; at that edge cout SHALL equal the final carry.
REQ-021 Latency: if start is sampled at edge k, done SHALL be high during the cycle following edge k+NDIG.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-023 start while busy=1 SHALL be ignored, with no effect on latched operands or results.
REQ-024 A start asserted in the IDLE cycle directly after DONE SHALL be accepted (back-to-back operations).
REQ-025 sum, cout and err SHALL hold their values from DONE until the next accepted start.
REQ-026 Operand inputs SHALL not affect the operation after the latch edge.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously and from any state (including mid-ADD):
- state = IDLE, digit index = 0;
- busy = 0, done = 0, sum = 0, cout = 0, err = 0.
REQ-028 After reset deassertion, the first start SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state enumeration (IDLE, ADD, DONE);
- the BCD_DIGIT_W = 4 constant;
- the BCD correction constant 6;
- the decimal limit 9.
REQ-030 A combinational sub-module bcd_digit_add SHALL implement REQ-016.
- Ports: 4-bit x, 4-bit y, 1-bit ci, 4-bit s, 1-bit co.
- It SHALL be instantiated exactly once and time-shared across digits.
REQ-031 The digit index counter SHALL be sized to ceil(log2(NDIG)) bits, minimum 1.

Verification
REQ-032 NDIG=4: a=1234, b=5678, cin=0 -> done at start edge + 4 cycles, sum=6912, cout=0, err=0.
REQ-033 a=9999, b=0001, cin=0 -> sum=0000, cout=1; a=9999, b=9999, cin=1 -> sum=9999, cout=1.
REQ-034 start held high through two operations -> two done pulses exactly 6 cycles apart.
REQ-035 Pulses on start during ADD -> ignored; results match the first operands only.
REQ-036 rst_n low after the second ADD cycle -> outputs zero immediately; a new start afterwards yields a correct result.
REQ-037 a=000A, b=0000 -> err=1 at done, sum=0010, cout=0; the next valid operation clears err.
